// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART frame sequencer: data width, default
// FIFO depth / abort timeout, and the sequencer FSM state encoding.
package uart_pkg;

    localparam int UART_DATA_W     = 8;
    localparam int DEFAULT_DEPTH   = 8;
    localparam int DEFAULT_TIMEOUT = 15;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_CAPTURE
    } seq_state_t;

endpackage

// File: rtl/uart_byte_fifo.sv
// uart_byte_fifo
// Circular byte FIFO feeding the frame sequencer. Pointers wrap modulo
// DEPTH (power of two), count tracks 0..DEPTH. A push while full is
// refused even if a pop happens in the same cycle. No bypass path: a
// pushed byte is visible at head only from the following cycle.
// Ports:
//   clk_in, rst         clock, synchronous active-high reset
//   push, push_data     write request and byte
//   pop                 remove head (ignored when empty)
//   head                byte at the read pointer
//   full, empty, count  occupancy status
module uart_byte_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                   clk_in,
    input  logic                   rst,
    input  logic                   push,
    input  logic [UART_DATA_W-1:0] push_data,
    input  logic                   pop,
    output logic [UART_DATA_W-1:0] head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [UART_DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic                   do_push;
    logic                   do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk_in) begin
        if (!rst && do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_frame_sequencer.sv
// uart_frame_sequencer
// Queues bytes in a FIFO and drives a UART core one frame at a time:
// IDLE -> LOAD (present byte, run=0) -> RUN (run=1, wait for done or
// abort after TIMEOUT cycles) -> CAPTURE (latch received byte, pop).
// Ports:
//   clk_in, rst              clock, synchronous active-high reset
//   in_data/in_valid/in_ready byte input stream into the FIFO
//   uart_din, uart_run       byte and run control towards the UART core
//   uart_done/dout/err       completion, received byte, parity error
//   rx_data/rx_err/rx_valid  captured result, rx_valid pulses once
//   timeout                  one-cycle pulse when a frame is aborted
//   fifo_count, busy         FIFO occupancy, FSM not idle
module uart_frame_sequencer
    import uart_pkg::*;
#(
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                   clk_in,
    input  logic                   rst,
    input  logic [UART_DATA_W-1:0] in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [UART_DATA_W-1:0] uart_din,
    output logic                   uart_run,
    input  logic                   uart_done,
    input  logic [UART_DATA_W-1:0] uart_dout,
    input  logic                   uart_err,
    output logic [UART_DATA_W-1:0] rx_data,
    output logic                   rx_err,
    output logic                   rx_valid,
    output logic                   timeout,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   busy
);

    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    seq_state_t             state;
    logic [CNT_W-1:0]       wait_cnt;
    logic [UART_DATA_W-1:0] din_q;
    logic [UART_DATA_W-1:0] fifo_head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   timed_out;
    logic                   more_after_pop;

    assign in_ready  = ~fifo_full;
    assign fifo_push = in_valid & in_ready;
    assign busy      = (state != ST_IDLE);

    // Done has priority over the abort on the boundary cycle.
    assign timed_out = (state == ST_RUN) && !uart_done &&
                       (wait_cnt == CNT_W'(TIMEOUT));
    assign fifo_pop  = (state == ST_CAPTURE) || timed_out;

    // Occupancy after this cycle's pop, including a concurrent push.
    assign more_after_pop = (fifo_count > CW'(1)) || fifo_push;

    // In LOAD the head is shown directly so the byte pushed or exposed by
    // the previous edge is presented without an extra cycle; din_q then
    // holds it through RUN and afterwards.
    assign uart_din = (state == ST_LOAD) ? fifo_head : din_q;

    uart_byte_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk_in   (clk_in),
        .rst      (rst),
        .push     (fifo_push),
        .push_data(in_data),
        .pop      (fifo_pop),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            din_q    <= '0;
            uart_run <= 1'b0;
            rx_data  <= '0;
            rx_err   <= 1'b0;
            rx_valid <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            timeout  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    din_q    <= fifo_head;
                    wait_cnt <= '0;
                    uart_run <= 1'b1;
                    state    <= ST_RUN;
                end
                ST_RUN: begin
                    if (uart_done) begin
                        rx_data  <= uart_dout;
                        rx_err   <= uart_err;
                        rx_valid <= 1'b1;
                        uart_run <= 1'b0;
                        state    <= ST_CAPTURE;
                    end else if (timed_out) begin
                        timeout  <= 1'b1;
                        uart_run <= 1'b0;
                        state    <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                ST_CAPTURE: begin
                    state <= more_after_pop ? ST_LOAD : ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_sequencer.sv
// tb_uart_frame_sequencer
// Directed bench for uart_frame_sequencer with a small behavioural UART
// that echoes the presented byte after a programmable number of run cycles.
module tb_uart_frame_sequencer;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 15;

    logic       clk_in = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] uart_din;
    logic       uart_run;
    logic       uart_done = 1'b0;
    logic [7:0] uart_dout = 8'h00;
    logic       uart_err  = 1'b0;
    logic [7:0] rx_data;
    logic       rx_err;
    logic       rx_valid;
    logic       timeout;
    logic [3:0] fifo_count;
    logic       busy;

    always #5 clk_in = ~clk_in;

    uart_frame_sequencer #(
        .DEPTH  (DEPTH),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .uart_din  (uart_din),
        .uart_run  (uart_run),
        .uart_done (uart_done),
        .uart_dout (uart_dout),
        .uart_err  (uart_err),
        .rx_data   (rx_data),
        .rx_err    (rx_err),
        .rx_valid  (rx_valid),
        .timeout   (timeout),
        .fifo_count(fifo_count),
        .busy      (busy)
    );

    // UART model: done rises model_delay+1 cycles into run (RUN counter
    // value model_delay+1) and is held until run drops.
    logic        model_en    = 1'b1;
    int unsigned model_delay = 3;
    logic        model_err   = 1'b0;
    int unsigned rcnt        = 0;

    always @(posedge clk_in) begin
        if (!uart_run) begin
            uart_done <= 1'b0;
            rcnt      <= 0;
        end else begin
            rcnt <= rcnt + 1;
            if (model_en && rcnt == model_delay) begin
                uart_done <= 1'b1;
                uart_dout <= uart_din;
                uart_err  <= model_err;
            end
        end
    end

    // Monitor
    logic [7:0]  load_q[$];
    int unsigned n_rx = 0, n_to = 0, n_rise = 0;
    int unsigned run_len = 0, last_len = 0, to_len = 0, cap_len = 0;
    logic        prev_run = 1'b0;

    always @(negedge clk_in) begin
        if (uart_run) begin
            if (!prev_run) n_rise++;
            run_len++;
        end else if (prev_run) begin
            last_len = run_len;
            run_len  = 0;
        end
        prev_run = uart_run;
        if (busy && !uart_run && !rx_valid) load_q.push_back(uart_din);
        if (rx_valid) begin
            n_rx++;
            cap_len = last_len;
        end
        if (timeout) begin
            n_to++;
            to_len = last_len;
        end
    end

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        load_q.delete();
        n_rx   = 0;
        n_to   = 0;
        n_rise = 0;
    endtask

    task automatic wait_idle(input string tag);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk_in);
            if (!busy && fifo_count == 0) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq(tag, 32'(ok), 32'd1);
        repeat (2) @(negedge clk_in);
    endtask

    task automatic push_one(input logic [7:0] b);
        in_data  = b;
        in_valid = 1'b1;
        @(negedge clk_in);
        in_valid = 1'b0;
    endtask

    initial begin
        bit hit;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk_in);

        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_count",    32'(fifo_count), 32'd0);
        check_eq("rst_busy",     32'(busy), 32'd0);
        check_eq("rst_run",      32'(uart_run), 32'd0);
        check_eq("rst_din",      32'(uart_din), 32'd0);
        check_eq("rst_rxv",      32'(rx_valid), 32'd0);
        check_eq("rst_to",       32'(timeout), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk_in);

        // Single frame, latency N+1 idle, N+2 LOAD, N+3 RUN
        clear_mon();
        model_delay = 3;
        push_one(8'hA5);
        check_eq("lat_count_n1", 32'(fifo_count), 32'd1);
        check_eq("lat_busy_n1",  32'(busy), 32'd0);
        @(negedge clk_in);
        check_eq("lat_load_busy", 32'(busy), 32'd1);
        check_eq("lat_load_run",  32'(uart_run), 32'd0);
        check_eq("lat_load_din",  32'(uart_din), 32'hA5);
        @(negedge clk_in);
        check_eq("lat_run_n3", 32'(uart_run), 32'd1);
        wait_idle("a5_idle");
        check_eq("a5_nrx",   n_rx, 32'd1);
        check_eq("a5_rxd",   32'(rx_data), 32'hA5);
        check_eq("a5_rxerr", 32'(rx_err), 32'd0);
        check_eq("a5_din_hold", 32'(uart_din), 32'hA5);

        // Fill to full, refused 9th push, ordered frames
        clear_mon();
        model_delay = 5;
        for (int i = 1; i <= 8; i++) begin
            in_data  = 8'(i);
            in_valid = 1'b1;
            @(negedge clk_in);
        end
        check_eq("full_count", 32'(fifo_count), 32'd8);
        check_eq("full_ready", 32'(in_ready), 32'd0);
        in_data = 8'h09;
        @(negedge clk_in);
        in_valid = 1'b0;
        check_eq("full_refuse_count", 32'(fifo_count), 32'd8);
        wait_idle("full_idle");
        check_eq("full_rises", n_rise, 32'd8);
        check_eq("full_nrx",   n_rx, 32'd8);
        check_eq("full_nload", load_q.size(), 32'd8);
        for (int i = 0; i < load_q.size() && i < 8; i++) begin
            check_eq($sformatf("full_load%0d", i), 32'(load_q[i]), 32'(i + 1));
        end
        check_eq("full_last_rx", 32'(rx_data), 32'h08);

        // Parity error capture
        clear_mon();
        model_delay = 2;
        model_err   = 1'b1;
        push_one(8'h3C);
        wait_idle("err_idle");
        check_eq("err_nrx",   n_rx, 32'd1);
        check_eq("err_rxd",   32'(rx_data), 32'h3C);
        check_eq("err_rxerr", 32'(rx_err), 32'd1);
        model_err = 1'b0;

        // Timeout: first byte dropped, second proceeds
        clear_mon();
        model_en = 1'b0;
        push_one(8'h11);
        push_one(8'h22);
        hit = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk_in);
            if (timeout) begin
                hit = 1'b1;
                break;
            end
        end
        check_eq("to_seen",  32'(hit), 32'd1);
        check_eq("to_count", 32'(fifo_count), 32'd1);
        model_en    = 1'b1;
        model_delay = 3;
        wait_idle("to_idle");
        check_eq("to_npulse", n_to, 32'd1);
        // Run held for counter values 0..TIMEOUT; pulse is registered.
        check_eq("to_runlen", to_len, 32'(TIMEOUT + 1));
        check_eq("to_nrx",    n_rx, 32'd1);
        check_eq("to_rxd",    32'(rx_data), 32'h22);
        check_eq("to_nload",  load_q.size(), 32'd2);

        // Done on the boundary cycle wins over timeout
        clear_mon();
        model_delay = TIMEOUT - 1;
        push_one(8'h5A);
        wait_idle("edge_idle");
        check_eq("edge_nrx",    n_rx, 32'd1);
        check_eq("edge_nto",    n_to, 32'd0);
        check_eq("edge_rxd",    32'(rx_data), 32'h5A);
        check_eq("edge_runlen", cap_len, 32'(TIMEOUT + 1));

        // Reset mid-frame with bytes queued, push during reset ignored
        clear_mon();
        model_en = 1'b0;
        push_one(8'h71);
        push_one(8'h72);
        push_one(8'h73);
        hit = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_in);
            if (uart_run) begin
                hit = 1'b1;
                break;
            end
        end
        check_eq("mrst_run_seen", 32'(hit), 32'd1);
        repeat (3) @(negedge clk_in);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hEE;
        @(negedge clk_in);
        rst      = 1'b0;
        in_valid = 1'b0;
        check_eq("mrst_run",   32'(uart_run), 32'd0);
        check_eq("mrst_din",   32'(uart_din), 32'd0);
        check_eq("mrst_rxd",   32'(rx_data), 32'd0);
        check_eq("mrst_rxerr", 32'(rx_err), 32'd0);
        check_eq("mrst_rxv",   32'(rx_valid), 32'd0);
        check_eq("mrst_to",    32'(timeout), 32'd0);
        check_eq("mrst_busy",  32'(busy), 32'd0);
        check_eq("mrst_count", 32'(fifo_count), 32'd0);
        check_eq("mrst_ready", 32'(in_ready), 32'd1);
        repeat (40) @(negedge clk_in);
        check_eq("mrst_after_nrx",   n_rx, 32'd0);
        check_eq("mrst_after_nto",   n_to, 32'd0);
        check_eq("mrst_after_count", 32'(fifo_count), 32'd0);
        check_eq("mrst_after_busy",  32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_frame_sequencer.md
UART_FRAME_SEQUENCER -- requirements
Module: uart_frame_sequencer

Interface
REQ-001 Parameter DEPTH, default 8, TX byte FIFO depth (power of two, 2..16).
REQ-002 Parameter TIMEOUT, default 15, max cycles waiting for uart_done before abort.
REQ-003 clk_in  input  1  sole clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_data  input  8  byte to transmit.
REQ-006 in_valid  input  1  in_data valid.
REQ-007 in_ready  output  1  FIFO can accept; push = in_valid & in_ready.
REQ-008 uart_din  output  8  byte presented to UART core.
REQ-009 uart_run  output  1  UART run control (0 = load/clear, 1 = transmit).
REQ-010 uart_done  input  1  UART frame complete, held until run=0.
REQ-011 uart_dout  input  8  UART received byte, valid while uart_done=1.
REQ-012 uart_err  input  1  UART parity error, valid while uart_done=1.
REQ-013 rx_data  output  8  captured received byte.
REQ-014 rx_err  output  1  captured parity error.
REQ-015 rx_valid  output  1  one-cycle pulse: rx_data/rx_err updated.
REQ-016 timeout  output  1  one-cycle pulse: frame aborted, no uart_done.
REQ-017 fifo_count  output  $clog2(DEPTH)+1  bytes stored.
REQ-018 busy  output  1  high in any state except IDLE.

Function
REQ-019 FIFO SHALL be circular, wr/rd pointers wrapping modulo DEPTH, count 0..DEPTH.
REQ-020 in_ready SHALL equal (fifo_count != DEPTH), combinational from count.
REQ-021 Push when full SHALL be refused; push+pop same cycle when full: pop occurs, push refused.
REQ-022 Push+pop same cycle when not full: both occur, count unchanged.
REQ-023 No bypass: a byte pushed into empty FIFO is visible to the FSM the next cycle.
REQ-024 FSM states IDLE, LOAD, RUN, CAPTURE.
REQ-025 IDLE: uart_run=0; go LOAD when fifo_count != 0.
REQ-026 LOAD (exactly 1 cycle): uart_run=0, uart_din=FIFO head; go RUN.
REQ-027 RUN: uart_run=1, uart_din held; wait counter increments each cycle from 0.
REQ-028 RUN with uart_done=1 sampled: latch uart_dout->rx_data, uart_err->rx_err, go CAPTURE.
REQ-029 RUN with counter==TIMEOUT and uart_done=0: pop head (byte dropped), pulse timeout, go IDLE.
REQ-030 uart_done=1 on the same cycle counter==TIMEOUT: done wins, no timeout.
REQ-031 CAPTURE (exactly 1 cycle): uart_run=0, rx_valid=1, pop head; go LOAD if count after pop != 0, else IDLE.
REQ-032 uart_din SHALL be held at the last loaded byte outside LOAD/RUN.
REQ-033 Latency: push into empty idle FIFO at cycle N -> LOAD at N+2, uart_run=1 at N+3.
REQ-034 uart_run SHALL be low for at least one cycle between consecutive frames.
REQ-035 rx_data/rx_err SHALL hold until the next capture.

Reset
REQ-036 On rst: state IDLE, pointers and count 0, wait counter 0.
REQ-037 On rst: uart_run=0, uart_din=0, rx_data=0, rx_err=0, rx_valid=0, timeout=0, busy=0; in_ready=1.
REQ-038 rst mid-frame SHALL abort immediately, discard FIFO contents, emit no rx_valid/timeout.
REQ-039 Push attempted during rst SHALL be ignored.

Structure
REQ-040 Shared package uart_pkg: FSM state enum, UART_DATA_W=8, default DEPTH and TIMEOUT constants.
REQ-041 FIFO SHALL be a sub-module uart_byte_fifo (push/pop/full/empty/count); FSM and capture in top.

Verification
REQ-042 Push 0xA5 into empty FIFO, uart model returns done with dout=0xA5, err=0 -> uart_din=0xA5 in LOAD, rx_valid once, rx_data=0xA5, rx_err=0.
REQ-043 Push 8 bytes 0x01..0x08 back-to-back, 9th push -> in_ready=0 at count 8, 9th refused, frames sent in order 0x01..0x08 with run low between each.
REQ-044 Model returns dout=0x3C, err=1 -> rx_err=1, rx_data=0x3C, single rx_valid.
REQ-045 Model never asserts done -> timeout pulse exactly TIMEOUT cycles into RUN, byte dropped, count decremented, next byte proceeds.
REQ-046 done asserted on cycle counter==TIMEOUT -> rx_valid, no timeout.
REQ-047 Assert rst during RUN with 3 bytes queued -> next cycle all outputs at reset values, count=0, no rx_valid/timeout.
